// File: rtl/rl_ram_pkg.sv
// rl_ram_pkg: shared FSM state type and byte-enable width helper for the arbitrated 1R1W RAM front end.
package rl_ram_pkg;
  typedef enum logic {INIT, RUN} state_e;
  function automatic int be_bits(input int dbits);
    return (dbits + 7) / 8;
  endfunction
endpackage

// File: rtl/rl_rr_arbiter.sv
// rl_rr_arbiter: combinational round-robin grant with a registered priority pointer.
module rl_rr_arbiter #(
  parameter int PORTS = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [PORTS-1:0] req_i,
  input  logic             adv_i,
  output logic [PORTS-1:0] gnt_o
);
  localparam int PW = $clog2(PORTS);
  logic [PW-1:0] ptr_q, ptr_d;
  always_comb begin
    int idx;
    logic [PORTS-1:0] oh;
    gnt_o = '0;
    ptr_d = ptr_q;
    // walk backwards so the requester closest to the pointer wins last
    for (int i = PORTS - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % PORTS;
      oh  = PORTS'(1) << idx;
      if (|(req_i & oh)) begin
        gnt_o = oh;
        ptr_d = adv_i ? PW'((idx + 1) % PORTS) : ptr_q;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/rl_ram_1r1w_arb.sv
// rl_ram_1r1w_arb: clears an external 1R1W RAM after reset, then round-robin arbitrates
// independent write and read requesters onto it with write-to-read forwarding on collisions.
module rl_ram_1r1w_arb import rl_ram_pkg::*; #(
  parameter  int ABITS = 8,
  parameter  int DBITS = 8,
  parameter  int PORTS = 2,
  localparam int BE    = be_bits(DBITS)
) (
  input  logic                   rst_ni,
  input  logic                   clk_i,
  input  logic [PORTS-1:0]       wreq_i,
  input  logic [PORTS*ABITS-1:0] waddr_i,
  input  logic [PORTS*DBITS-1:0] wdata_i,
  input  logic [PORTS*BE-1:0]    wbe_i,
  output logic [PORTS-1:0]       wgnt_o,
  input  logic [PORTS-1:0]       rreq_i,
  input  logic [PORTS*ABITS-1:0] raddr_i,
  output logic [PORTS-1:0]       rgnt_o,
  output logic [PORTS-1:0]       rvalid_o,
  output logic [DBITS-1:0]       rdata_o,
  output logic [ABITS-1:0]       ram_waddr_o,
  output logic [DBITS-1:0]       ram_din_o,
  output logic                   ram_we_o,
  output logic [BE-1:0]          ram_be_o,
  output logic [ABITS-1:0]       ram_raddr_o,
  output logic                   ram_re_o,
  input  logic [DBITS-1:0]       ram_dout_i,
  output logic                   init_busy_o
);
  state_e           state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [PORTS-1:0] rvalid_q, rvalid_d;
  logic             coll_q, coll_d;
  logic [DBITS-1:0] cdata_q, cdata_d;
  logic [BE-1:0]    cbe_q, cbe_d;
  logic             run;
  assign run         = state_q == RUN;
  assign init_busy_o = !run;
  assign rvalid_o    = rvalid_q;
  rl_rr_arbiter #(.PORTS(PORTS)) u_warb (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(wreq_i & {PORTS{run}}), .adv_i(run), .gnt_o(wgnt_o)
  );
  rl_rr_arbiter #(.PORTS(PORTS)) u_rarb (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(rreq_i & {PORTS{run}}), .adv_i(run), .gnt_o(rgnt_o)
  );
  always_comb begin
    state_d     = run ? RUN : (&addr_q ? RUN : INIT);
    addr_d      = (run || &addr_q) ? addr_q : addr_q + ABITS'(1);
    // the clear write is masked while reset is held so the RAM sees no strobe
    ram_we_o    = run ? |wgnt_o : rst_ni;
    ram_waddr_o = run ? '0 : addr_q;
    ram_din_o   = '0;
    ram_be_o    = run ? '0 : '1;
    ram_raddr_o = '0;
    ram_re_o    = |rgnt_o;
    for (int p = 0; p < PORTS; p++) begin
      if (wgnt_o[p]) begin
        ram_waddr_o = waddr_i[p*ABITS +: ABITS];
        ram_din_o   = wdata_i[p*DBITS +: DBITS];
        ram_be_o    = wbe_i[p*BE +: BE];
      end
      if (rgnt_o[p]) ram_raddr_o = raddr_i[p*ABITS +: ABITS];
    end
    rvalid_d = rgnt_o;
    coll_d   = ram_we_o && ram_re_o && ram_waddr_o == ram_raddr_o;
    cdata_d  = ram_din_o;
    cbe_d    = ram_be_o;
    for (int i = 0; i < DBITS; i++) rdata_o[i] = (coll_q && cbe_q[i/8]) ? cdata_q[i] : ram_dout_i[i];
    if (rvalid_q == '0) rdata_o = '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q  <= INIT;
      addr_q   <= '0;
      rvalid_q <= '0;
      coll_q   <= 1'b0;
      cdata_q  <= '0;
      cbe_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rvalid_q <= rvalid_d;
      coll_q   <= coll_d;
      cdata_q  <= cdata_d;
      cbe_q    <= cbe_d;
    end
endmodule
